// File: rtl/tri_raster_ctrl_pkg.sv
// Shared types and helpers for the triangle raster sequencer.
package tri_pkg;

    // Coordinate width (two's complement) and hit counter width.
    localparam int unsigned W  = 12;
    localparam int unsigned CW = 2 * W + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        E0,
        E1,
        E2,
        OUT,
        DONE
    } state_t;

    typedef struct packed {
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
    } point_t;

    function automatic logic signed [W-1:0] smin3(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b,
                                                  input logic signed [W-1:0] c);
        logic signed [W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [W-1:0] smax3(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b,
                                                  input logic signed [W-1:0] c);
        logic signed [W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/tri_raster_ctrl_if.sv
// Triangle input, point output and status bundle of the raster sequencer.
interface tri_raster_ctrl_if;
    import tri_pkg::*;

    logic          tri_valid;
    logic          tri_ready;
    logic [W-1:0]  p1x;
    logic [W-1:0]  p1y;
    logic [W-1:0]  p2x;
    logic [W-1:0]  p2y;
    logic [W-1:0]  p3x;
    logic [W-1:0]  p3y;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_x;
    logic [W-1:0]  out_y;
    logic          busy;
    logic          done;
    logic [CW-1:0] hit_cnt;

    // Triangle source / pixel consumer side.
    modport master (
        output tri_valid, p1x, p1y, p2x, p2y, p3x, p3y, abort, out_ready,
        input  tri_ready, out_valid, out_x, out_y, busy, done, hit_cnt
    );

    // Sequencer side.
    modport slave (
        input  tri_valid, p1x, p1y, p2x, p2y, p3x, p3y, abort, out_ready,
        output tri_ready, out_valid, out_x, out_y, busy, done, hit_cnt
    );

endinterface

// File: rtl/tri_raster_ctrl_edge_sign.sv
// Combinational edge-sign test shared by all three triangle edges.
module edge_sign
    import tri_pkg::*;
(
    input  point_t i_pt,
    input  point_t i_p,
    input  point_t i_q,
    output logic   o_sign
);

    logic signed [W-1:0]   w_a1;
    logic signed [W-1:0]   w_a2;
    logic signed [W-1:0]   w_a3;
    logic signed [W-1:0]   w_a4;
    logic signed [2*W-1:0] w_m1;
    logic signed [2*W-1:0] w_m2;

    // Differences wrap at W bits; products are full 2W-bit signed.
    assign w_a1 = i_pt.x - i_q.x;
    assign w_a2 = i_p.y  - i_q.y;
    assign w_a3 = i_p.x  - i_q.x;
    assign w_a4 = i_pt.y - i_q.y;

    assign w_m1 = (2*W)'(w_a1) * (2*W)'(w_a2);
    assign w_m2 = (2*W)'(w_a3) * (2*W)'(w_a4);

    assign o_sign = (w_m1 < w_m2);

endmodule

// File: rtl/tri_raster_ctrl.sv
// Triangle raster sequencer: scans the bounding box row-major, tests each point
// against the three edges with one shared edge-sign unit, streams contained points.
module tri_raster_ctrl
    import tri_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    tri_raster_ctrl_if.slave bus
);

    localparam logic signed [W-1:0] One = W'(1);

    state_t              r_state;
    point_t              r_v1;
    point_t              r_v2;
    point_t              r_v3;
    point_t              r_cur;
    point_t              r_out;
    logic signed [W-1:0] r_xmin;
    logic signed [W-1:0] r_xmax;
    logic signed [W-1:0] r_ymin;
    logic signed [W-1:0] r_ymax;
    logic                r_s0;
    logic                r_s1;
    logic                r_out_valid;
    logic                r_done;
    logic [CW-1:0]       r_hit_cnt;

    point_t              w_p;
    point_t              w_q;
    logic                w_sign;
    logic                w_hit;
    logic                w_last;
    point_t              w_next;
    logic signed [W-1:0] w_xmin;
    logic signed [W-1:0] w_xmax;
    logic signed [W-1:0] w_ymin;
    logic signed [W-1:0] w_ymax;

    // Select the vertex pair for the edge evaluated in the current state.
    always_comb begin
        w_p = r_v1;
        w_q = r_v2;
        unique case (r_state)
            E1: begin
                w_p = r_v2;
                w_q = r_v3;
            end
            E2: begin
                w_p = r_v3;
                w_q = r_v1;
            end
            default: begin
                w_p = r_v1;
                w_q = r_v2;
            end
        endcase
    end

    edge_sign u_edge_sign (
        .i_pt   (r_cur),
        .i_p    (w_p),
        .i_q    (w_q),
        .o_sign (w_sign)
    );

    // Bounding box from the latched vertices, signed compare.
    always_comb begin
        w_xmin = smin3(r_v1.x, r_v2.x, r_v3.x);
        w_xmax = smax3(r_v1.x, r_v2.x, r_v3.x);
        w_ymin = smin3(r_v1.y, r_v2.y, r_v3.y);
        w_ymax = smax3(r_v1.y, r_v2.y, r_v3.y);
    end

    // Containment decision and row-major advance of the scan position.
    always_comb begin
        w_hit  = (r_s0 == r_s1) && (r_s1 == w_sign);
        w_last = (r_cur.x == r_xmax) && (r_cur.y == r_ymax);
        w_next = r_cur;
        if (r_cur.x == r_xmax) begin
            w_next.x = r_xmin;
            w_next.y = r_cur.y + One;
        end else begin
            w_next.x = r_cur.x + One;
        end
    end

    // Sequencer FSM with scan counters, bbox, sign registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_v1        <= '0;
            r_v2        <= '0;
            r_v3        <= '0;
            r_cur       <= '0;
            r_out       <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_ymin      <= '0;
            r_ymax      <= '0;
            r_s0        <= 1'b0;
            r_s1        <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_hit_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort && (r_state != IDLE)) begin
                // Cancel: no done pulse, hit count keeps its value.
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (bus.tri_valid) begin
                            r_v1      <= '{x: bus.p1x, y: bus.p1y};
                            r_v2      <= '{x: bus.p2x, y: bus.p2y};
                            r_v3      <= '{x: bus.p3x, y: bus.p3y};
                            r_hit_cnt <= '0;
                            r_state   <= SETUP;
                        end
                    end
                    SETUP: begin
                        r_xmin  <= w_xmin;
                        r_xmax  <= w_xmax;
                        r_ymin  <= w_ymin;
                        r_ymax  <= w_ymax;
                        r_cur   <= '{x: w_xmin, y: w_ymin};
                        r_state <= E0;
                    end
                    E0: begin
                        r_s0    <= w_sign;
                        r_state <= E1;
                    end
                    E1: begin
                        r_s1    <= w_sign;
                        r_state <= E2;
                    end
                    E2: begin
                        if (w_hit) begin
                            r_out       <= r_cur;
                            r_out_valid <= 1'b1;
                            r_state     <= OUT;
                        end else if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            r_cur   <= w_next;
                            r_state <= E0;
                        end
                    end
                    OUT: begin
                        if (bus.out_ready) begin
                            r_out_valid <= 1'b0;
                            r_hit_cnt   <= r_hit_cnt + CW'(1);
                            if (w_last) begin
                                r_state <= DONE;
                            end else begin
                                r_cur   <= w_next;
                                r_state <= E0;
                            end
                        end
                    end
                    DONE: begin
                        // The pulse lands in the cycle after DONE, alongside tri_ready.
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tri_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_x     = r_out.x;
    assign bus.out_y     = r_out.y;
    assign bus.done      = r_done;
    assign bus.hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// Directed testbench for tri_raster_ctrl.
module tb_tri_raster_ctrl;
    import tri_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tri_raster_ctrl_if u_if ();

    tri_raster_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    int tests = 0;
    int fails = 0;
    int got_x[$];
    int got_y[$];
    int exp_x[$];
    int exp_y[$];
    int done_cnt;
    int seen_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy);
        u_if.p1x = ax[W-1:0];
        u_if.p1y = ay[W-1:0];
        u_if.p2x = bx[W-1:0];
        u_if.p2y = by[W-1:0];
        u_if.p3x = cx[W-1:0];
        u_if.p3y = cy[W-1:0];
        u_if.tri_valid = 1'b1;
        tick();
        u_if.tri_valid = 1'b0;
    endtask

    // Run a job to its done pulse; mode 0 = always ready, mode 1 = random ready.
    task automatic collect(input int mode);
        int prev_stall;
        int px;
        int py;
        got_x.delete();
        got_y.delete();
        done_cnt = 0;
        seen_done = 0;
        prev_stall = 0;
        px = 0;
        py = 0;
        for (int c = 0; c < 2000 && seen_done == 0; c++) begin
            tick();
            if (prev_stall != 0) begin
                tests++;
                if (u_if.out_valid !== 1'b1 || int'($signed(u_if.out_x)) != px ||
                    int'($signed(u_if.out_y)) != py) begin
                    fails++;
                    $display("FAIL stall_hold: got valid=%0b (%0d,%0d) want valid=1 (%0d,%0d)",
                             u_if.out_valid, $signed(u_if.out_x), $signed(u_if.out_y), px, py);
                end
            end
            u_if.out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            prev_stall = (u_if.out_valid === 1'b1 && u_if.out_ready == 1'b0) ? 1 : 0;
            px = int'($signed(u_if.out_x));
            py = int'($signed(u_if.out_y));
            if (u_if.out_valid === 1'b1 && u_if.out_ready == 1'b1) begin
                got_x.push_back(int'($signed(u_if.out_x)));
                got_y.push_back(int'($signed(u_if.out_y)));
            end
            if (u_if.done === 1'b1) begin
                done_cnt++;
                seen_done = 1;
            end
        end
        tests++;
        if (seen_done == 0) begin
            fails++;
            $display("FAIL job_timeout: got no done within budget, want done");
        end
        // Make sure the pulse is single and nothing more streams out.
        for (int c = 0; c < 3; c++) begin
            tick();
            if (u_if.done === 1'b1) done_cnt++;
            if (u_if.out_valid === 1'b1) done_cnt += 100;
        end
    endtask

    function automatic bit m_sign(input int tx, input int ty, input int px, input int py,
                                  input int qx, input int qy);
        return ((tx - qx) * (py - qy)) < ((px - qx) * (ty - qy));
    endfunction

    function automatic bit m_inside(input int tx, input int ty, input int ax, input int ay,
                                    input int bx, input int by, input int cx, input int cy);
        bit s0;
        bit s1;
        bit s2;
        s0 = m_sign(tx, ty, ax, ay, bx, by);
        s1 = m_sign(tx, ty, bx, by, cx, cy);
        s2 = m_sign(tx, ty, cx, cy, ax, ay);
        return (s0 == s1) && (s1 == s2);
    endfunction

    task automatic build_right_tri(input int off);
        exp_x.delete();
        exp_y.delete();
        for (int y = 0; y <= 4; y++) begin
            for (int x = 0; x <= 4 - y; x++) begin
                exp_x.push_back(x + off);
                exp_y.push_back(y + off);
            end
        end
    endtask

    task automatic test_reset();
        tests++;
        if (u_if.tri_ready !== 1'b1 || u_if.out_valid !== 1'b0 || u_if.busy !== 1'b0 ||
            u_if.done !== 1'b0 || u_if.hit_cnt !== '0 || u_if.out_x !== '0 ||
            u_if.out_y !== '0) begin
            fails++;
            $display("FAIL reset_values: got rdy=%0b ov=%0b busy=%0b done=%0b hc=%0d x=%0d y=%0d want 1 0 0 0 0 0 0",
                     u_if.tri_ready, u_if.out_valid, u_if.busy, u_if.done, u_if.hit_cnt,
                     u_if.out_x, u_if.out_y);
        end
    endtask

    task automatic test_basic();
        int bad;
        build_right_tri(0);
        start_job(0, 0, 4, 0, 0, 4);
        collect(0);
        bad = (got_x.size() != exp_x.size()) ? 1 : 0;
        for (int i = 0; i < got_x.size() && bad == 0; i++) begin
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) bad = 1;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL basic_seq: got %0d points first (%0d,%0d) want 15 points from (0,0)",
                     got_x.size(), got_x.size() > 0 ? got_x[0] : 0,
                     got_y.size() > 0 ? got_y[0] : 0);
        end
        tests++;
        if (u_if.hit_cnt !== CW'(15)) begin
            fails++;
            $display("FAIL basic_hit_cnt: got %0d want 15", u_if.hit_cnt);
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL basic_done: got %0d done/extra events want 1", done_cnt);
        end
    endtask

    task automatic test_winding();
        tests++;
        start_job(0, 0, 0, 4, 4, 0);
        collect(0);
        if (got_x.size() != 3 || got_x[0] != 1 || got_y[0] != 1 || got_x[1] != 2 ||
            got_y[1] != 1 || got_x[2] != 1 || got_y[2] != 2) begin
            fails++;
            $display("FAIL winding_seq: got %0d points want (1,1),(2,1),(1,2)", got_x.size());
        end
        tests++;
        if (u_if.hit_cnt !== CW'(3) || done_cnt != 1) begin
            fails++;
            $display("FAIL winding_cnt: got hit_cnt=%0d done=%0d want 3 and 1",
                     u_if.hit_cnt, done_cnt);
        end
    endtask

    task automatic test_single_point();
        start_job(5, 5, 5, 5, 5, 5);
        // Now in cycle 1 after the handshake.
        tests++;
        if (u_if.busy !== 1'b1 || u_if.tri_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_busy: got busy=%0b rdy=%0b want 1 0", u_if.busy, u_if.tri_ready);
        end
        u_if.out_ready = 1'b1;
        tick();
        tick();
        tick();
        tests++;
        if (u_if.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_early_valid: got %0b in cycle 4 want 0", u_if.out_valid);
        end
        tick();
        tests++;
        if (u_if.out_valid !== 1'b1 || u_if.out_x !== W'(5) || u_if.out_y !== W'(5)) begin
            fails++;
            $display("FAIL single_out_c5: got v=%0b (%0d,%0d) want 1 (5,5)",
                     u_if.out_valid, u_if.out_x, u_if.out_y);
        end
        tick();
        tests++;
        if (u_if.out_valid !== 1'b0 || u_if.done !== 1'b0 || u_if.hit_cnt !== CW'(1)) begin
            fails++;
            $display("FAIL single_c6: got v=%0b done=%0b hc=%0d want 0 0 1",
                     u_if.out_valid, u_if.done, u_if.hit_cnt);
        end
        tick();
        tests++;
        if (u_if.done !== 1'b1 || u_if.tri_ready !== 1'b1 || u_if.hit_cnt !== CW'(1)) begin
            fails++;
            $display("FAIL single_done_c7: got done=%0b rdy=%0b hc=%0d want 1 1 1",
                     u_if.done, u_if.tri_ready, u_if.hit_cnt);
        end
        tick();
        tests++;
        if (u_if.done !== 1'b0) begin
            fails++;
            $display("FAIL single_done_width: got done=%0b in cycle 8 want 0", u_if.done);
        end
    endtask

    task automatic test_negative();
        int bad;
        exp_x.delete();
        exp_y.delete();
        for (int y = -3; y <= 1; y++) begin
            for (int x = -3; x <= 1; x++) begin
                if (m_inside(x, y, -3, -3, 1, -3, -3, 1)) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                end
            end
        end
        start_job(-3, -3, 1, -3, -3, 1);
        collect(0);
        bad = (got_x.size() != exp_x.size()) ? 1 : 0;
        for (int i = 0; i < got_x.size() && bad == 0; i++) begin
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) bad = 1;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL negative_seq: got %0d points want %0d", got_x.size(), exp_x.size());
        end
        tests++;
        if (got_x.size() == 0 || got_x[0] != -3 || got_y[0] != -3) begin
            fails++;
            $display("FAIL negative_first: got (%0d,%0d) want (-3,-3)",
                     got_x.size() > 0 ? got_x[0] : 0, got_y.size() > 0 ? got_y[0] : 0);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        build_right_tri(0);
        start_job(0, 0, 4, 0, 0, 4);
        collect(1);
        u_if.out_ready = 1'b1;
        bad = (got_x.size() != exp_x.size()) ? 1 : 0;
        for (int i = 0; i < got_x.size() && bad == 0; i++) begin
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) bad = 1;
        end
        tests++;
        if (bad != 0 || done_cnt != 1 || u_if.hit_cnt !== CW'(15)) begin
            fails++;
            $display("FAIL backpressure_seq: got %0d points done=%0d hc=%0d want 15 1 15",
                     got_x.size(), done_cnt, u_if.hit_cnt);
        end
    endtask

    task automatic test_abort();
        int accepted;
        int found;
        int extra;
        accepted = 0;
        found = 0;
        extra = 0;
        u_if.out_ready = 1'b0;
        start_job(0, 0, 4, 0, 0, 4);
        for (int c = 0; c < 200 && found == 0; c++) begin
            tick();
            u_if.out_ready = 1'b0;
            if (u_if.out_valid === 1'b1) begin
                if (accepted == 2) begin
                    found = 1;
                end else begin
                    u_if.out_ready = 1'b1;
                    accepted++;
                end
            end
        end
        tests++;
        if (found == 0 || u_if.out_x !== W'(2) || u_if.out_y !== W'(0)) begin
            fails++;
            $display("FAIL abort_third_point: got found=%0d (%0d,%0d) want (2,0)",
                     found, u_if.out_x, u_if.out_y);
        end
        u_if.abort = 1'b1;
        tick();
        u_if.abort = 1'b0;
        tests++;
        if (u_if.tri_ready !== 1'b1 || u_if.busy !== 1'b0 || u_if.out_valid !== 1'b0 ||
            u_if.done !== 1'b0 || u_if.hit_cnt !== CW'(2)) begin
            fails++;
            $display("FAIL abort_state: got rdy=%0b busy=%0b ov=%0b done=%0b hc=%0d want 1 0 0 0 2",
                     u_if.tri_ready, u_if.busy, u_if.out_valid, u_if.done, u_if.hit_cnt);
        end
        start_job(5, 5, 5, 5, 5, 5);
        tests++;
        if (u_if.busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_restart: got busy=%0b want 1", u_if.busy);
        end
        collect(0);
        for (int c = 0; c < 2; c++) begin
            tick();
            if (u_if.done === 1'b1) extra++;
        end
        tests++;
        if (got_x.size() != 1 || got_x[0] != 5 || got_y[0] != 5 || done_cnt != 1 ||
            extra != 0 || u_if.hit_cnt !== CW'(1)) begin
            fails++;
            $display("FAIL abort_next_job: got %0d points done=%0d hc=%0d want 1 1 1",
                     got_x.size(), done_cnt, u_if.hit_cnt);
        end
    endtask

    task automatic test_reset_mid_job();
        int leaks;
        leaks = 0;
        u_if.out_ready = 1'b1;
        start_job(0, 0, 4, 0, 0, 4);
        for (int c = 0; c < 9; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (u_if.tri_ready !== 1'b1 || u_if.out_valid !== 1'b0 || u_if.busy !== 1'b0 ||
            u_if.done !== 1'b0 || u_if.hit_cnt !== '0 || u_if.out_x !== '0 ||
            u_if.out_y !== '0) begin
            fails++;
            $display("FAIL reset_mid_job: got rdy=%0b ov=%0b busy=%0b done=%0b hc=%0d x=%0d y=%0d want 1 0 0 0 0 0 0",
                     u_if.tri_ready, u_if.out_valid, u_if.busy, u_if.done, u_if.hit_cnt,
                     u_if.out_x, u_if.out_y);
        end
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (u_if.out_valid === 1'b1 || u_if.busy === 1'b1 || u_if.done === 1'b1) leaks++;
        end
        tests++;
        if (leaks != 0) begin
            fails++;
            $display("FAIL reset_quiet: got %0d active cycles after reset want 0", leaks);
        end
    endtask

    initial begin
        u_if.tri_valid = 1'b0;
        u_if.p1x = '0;
        u_if.p1y = '0;
        u_if.p2x = '0;
        u_if.p2y = '0;
        u_if.p3x = '0;
        u_if.p3y = '0;
        u_if.abort = 1'b0;
        u_if.out_ready = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_winding();
        test_single_point();
        test_negative();
        test_backpressure();
        test_abort();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
